// File: rtl/register_dump_tx.sv
// register_dump_tx: serializes a snapshot of the flat register bank into a
// byte frame (header, register bytes MSB-first, optional checksum) over a
// valid/ready handshake.
module register_dump_tx #(
  parameter int          NUM_REGS      = 32,
  parameter int          REG_WIDTH     = 32,
  parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
  parameter bit          SEND_CHECKSUM = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_REGS*REG_WIDTH-1:0] registros,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int BPR    = REG_WIDTH / 8;
  localparam int NBYTES = NUM_REGS * BPR;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TOTW   = NUM_REGS * REG_WIDTH;
  localparam int OW     = $clog2(TOTW);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECK} state_t;

  state_t          state, state_nxt;
  logic [TOTW-1:0] snap;
  logic [CW-1:0]   byte_cnt;
  logic [7:0]      csum;
  logic [7:0]      data_byte;
  logic [OW-1:0]   bit_off;
  logic            xfer, last_byte, frame_end;
  int              reg_idx, sub_idx;

  assign xfer      = data_valid & data_ready;
  assign last_byte = (byte_cnt == CW'(NBYTES - 1));

  // Map the byte index to a bit offset: registers ascending, bytes MSB-first.
  always_comb begin
    reg_idx   = int'(byte_cnt) / BPR;
    sub_idx   = BPR - 1 - (int'(byte_cnt) % BPR);
    bit_off   = OW'(reg_idx * REG_WIDTH + sub_idx * 8);
    data_byte = snap[bit_off +: 8];
  end

  // State register; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs. Outputs hold while ready is low since
  // they depend only on state, snapshot and counters, which only move on xfer.
  always_comb begin
    state_nxt  = state;
    frame_end  = 1'b0;
    data_out   = 8'h00;
    data_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HEADER;
      end
      HEADER: begin
        data_out   = HEADER_BYTE;
        data_valid = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = DATA;
      end
      DATA: begin
        data_out   = data_byte;
        data_valid = 1'b1;
        busy       = 1'b1;
        if (xfer && last_byte) begin
          if (SEND_CHECKSUM) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = IDLE;
            frame_end = 1'b1;
          end
        end
      end
      CHECK: begin
        data_out   = csum;
        data_valid = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot capture; contents are don't-care until the first start.
  always_ff @(posedge clock) begin
    if (state == IDLE && start && !reset) snap <= registros;
  end

  // Byte counter, running checksum and the one-cycle done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= '0;
      csum     <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= frame_end;
      case (state)
        IDLE: if (start) begin
          byte_cnt <= '0;
          csum     <= 8'h00;
        end
        HEADER: if (xfer) byte_cnt <= '0;
        DATA: if (xfer) begin
          csum <= csum + data_out;
          if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_tx.sv
// Bench for register_dump_tx: two instances (with and without checksum),
// expected frames built from the bench's own copy of the register bank.
module tb_register_dump_tx;

  logic          clock = 1'b0;
  logic          reset, start0, start1, data_ready;
  logic [1023:0] registros;
  logic [7:0]    d0, d1;
  logic          v0, v1, b0, b1, dn0, dn1;

  logic [7:0]    exp_q[$];
  logic [7:0]    obs_q[$];
  logic          s_v, s_b, s_dn;
  logic [7:0]    s_d;
  int            checks = 0;
  int            errors = 0;

  always #5 clock = ~clock;

  register_dump_tx dut0 (
    .clock(clock), .reset(reset), .start(start0), .registros(registros),
    .data_out(d0), .data_valid(v0), .data_ready(data_ready), .busy(b0), .done(dn0)
  );

  register_dump_tx #(.SEND_CHECKSUM(1'b0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .registros(registros),
    .data_out(d1), .data_valid(v1), .data_ready(data_ready), .busy(b1), .done(dn1)
  );

  // Sample one DUT at the falling edge, log transfers, then step past the rising edge.
  task automatic tick(input int sel);
    @(negedge clock);
    s_v  = sel ? v1  : v0;
    s_b  = sel ? b1  : b0;
    s_dn = sel ? dn1 : dn0;
    s_d  = sel ? d1  : d0;
    if (s_v && data_ready) obs_q.push_back(s_d);
    @(posedge clock);
    #1;
  endtask

  task automatic set_regs(input int mode);
    for (int i = 0; i < 32; i++)
      registros[32*i +: 32] = (mode == 0) ? i : (mode == 1) ? 32'hFFFF_FFFF : 32'h0;
  endtask

  // Expected frame from the current bank: header, bytes MSB-first, checksum.
  task automatic push_frame(input bit cks);
    logic [7:0] sum, bt;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++)
      for (int b = 3; b >= 0; b--) begin
        bt = registros[32*i + 8*b +: 8];
        exp_q.push_back(bt);
        sum = sum + bt;
      end
    if (cks) exp_q.push_back(sum);
  endtask

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b1; start1 = 1'b1; data_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(0);
      checks++; if (s_v !== 1'b0)   begin errors++; $display("FAIL reset_valid c%0d: got %b want 0", c, s_v); end
      checks++; if (s_b !== 1'b0)   begin errors++; $display("FAIL reset_busy c%0d: got %b want 0", c, s_b); end
      checks++; if (s_dn !== 1'b0)  begin errors++; $display("FAIL reset_done c%0d: got %b want 0", c, s_dn); end
      checks++; if (s_d !== 8'h00)  begin errors++; $display("FAIL reset_data c%0d: got %h want 00", c, s_d); end
      checks++; if (v1 !== 1'b0)    begin errors++; $display("FAIL reset_valid_nocks c%0d: got %b want 0", c, v1); end
    end
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_full();
    int nvalid = 0, ndone = 0, first_v = -1, last_v = -1, done_at = -1;
    logic busy_at_done = 1'b1;
    logic [7:0] e, o;
    set_regs(0); data_ready = 1'b1;
    exp_q.delete(); obs_q.delete(); push_frame(1);
    start0 = 1'b1; tick(0); start0 = 1'b0;
    for (int c = 0; c < 140; c++) begin
      tick(0);
      if (s_v) begin nvalid++; last_v = c; if (first_v < 0) first_v = c; end
      if (s_dn) begin ndone++; done_at = c; busy_at_done = s_b; end
    end
    checks++; if (first_v != 0)   begin errors++; $display("FAIL full_latency: got %0d want 0", first_v); end
    checks++; if (nvalid != 130)  begin errors++; $display("FAIL full_valid_cycles: got %0d want 130", nvalid); end
    checks++; if (ndone != 1)     begin errors++; $display("FAIL full_done_count: got %0d want 1", ndone); end
    checks++; if (done_at != last_v + 1) begin errors++; $display("FAIL full_done_time: got %0d want %0d", done_at, last_v + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL full_busy_at_done: got %b want 0", busy_at_done); end
    checks++; if (s_b !== 1'b0)   begin errors++; $display("FAIL full_busy_after: got %b want 0", s_b); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL full_byte%0d: got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_backpressure();
    int ndone = 0, unstable = 0;
    logic pv = 1'b0, pr = 1'b1;
    logic [7:0] pd = 8'h00, e, o;
    set_regs(1);
    exp_q.delete(); obs_q.delete(); push_frame(1);
    start0 = 1'b1; data_ready = 1'b0; tick(0); start0 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick(0);
      if (pv && !pr && (!s_v || s_d !== pd)) unstable++;
      if (s_dn) ndone++;
      pv = s_v; pr = data_ready; pd = s_d;
      data_ready = ~data_ready;
    end
    data_ready = 1'b1;
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    checks++; if (ndone != 1)    begin errors++; $display("FAIL bp_done_count: got %0d want 1", ndone); end
    checks++; if (obs_q.size() != 130) begin errors++; $display("FAIL bp_len: got %0d want 130", obs_q.size()); end
    checks++; if (exp_q[exp_q.size()-1] !== 8'h80) begin errors++; $display("FAIL bp_model_cks: got %h want 80", exp_q[exp_q.size()-1]); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_snapshot();
    int ndone = 0, nvalid = 0;
    logic [7:0] e, o;
    set_regs(0); data_ready = 1'b1;
    exp_q.delete(); obs_q.delete(); push_frame(1);
    start0 = 1'b1; tick(0); start0 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      tick(0);
      if (s_v) nvalid++;
      if (s_dn) ndone++;
      if (c == 10) begin set_regs(2); start0 = 1'b1; end
      else start0 = 1'b0;
    end
    checks++; if (ndone != 1)    begin errors++; $display("FAIL snap_done_count: got %0d want 1", ndone); end
    checks++; if (nvalid != 130) begin errors++; $display("FAIL snap_valid_cycles: got %0d want 130", nvalid); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL snap_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL snap_byte%0d: got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0, nvalid = 0;
    logic [7:0] e, o;
    set_regs(0); data_ready = 1'b1;
    exp_q.delete(); obs_q.delete();
    start0 = 1'b1; tick(0); start0 = 1'b0;
    for (int c = 0; c < 60 && obs_q.size() < 20; c++) tick(0);
    checks++; if (obs_q.size() != 20) begin errors++; $display("FAIL rmid_reach20: got %0d want 20", obs_q.size()); end
    reset = 1'b1; tick(0); reset = 1'b0;
    tick(0);
    checks++; if (s_v !== 1'b0)  begin errors++; $display("FAIL rmid_valid: got %b want 0", s_v); end
    checks++; if (s_b !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b want 0", s_b); end
    for (int c = 0; c < 5; c++) begin
      if (s_dn) ndone++;
      if (s_v) nvalid++;
      tick(0);
    end
    checks++; if (ndone != 0)  begin errors++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rmid_idle: got %0d valid want 0", nvalid); end
    exp_q.delete(); obs_q.delete(); push_frame(1);
    nvalid = 0;
    start0 = 1'b1; tick(0); start0 = 1'b0;
    for (int c = 0; c < 140; c++) begin tick(0); if (s_v) nvalid++; end
    checks++; if (nvalid != 130) begin errors++; $display("FAIL rmid_refull_cycles: got %0d want 130", nvalid); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rmid_byte%0d: got %h want %h", k, o, e); end
    end
  endtask

  task automatic test_no_checksum();
    logic [7:0] e, o;
    set_regs(0); data_ready = 1'b1;
    exp_q.delete(); obs_q.delete(); push_frame(0);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    for (int c = 0; c < 140 && obs_q.size() < 129; c++) tick(1);
    // Now in the cycle after the final transfer: the done cycle.
    start1 = 1'b1; tick(1); start1 = 1'b0;
    checks++; if (s_dn !== 1'b1) begin errors++; $display("FAIL nocks_done: got %b want 1", s_dn); end
    checks++; if (s_v !== 1'b0)  begin errors++; $display("FAIL nocks_valid_at_done: got %b want 0", s_v); end
    tick(1);
    checks++; if (s_dn !== 1'b0) begin errors++; $display("FAIL nocks_done_width: got %b want 0", s_dn); end
    checks++; if (!(s_v === 1'b1 && s_d === 8'hA5)) begin errors++; $display("FAIL nocks_restart: got v=%b d=%h want v=1 d=a5", s_v, s_d); end
    if (obs_q.size() > 129) void'(obs_q.pop_back());
    checks++; if (obs_q.size() != 129) begin errors++; $display("FAIL nocks_len: got %0d want 129", obs_q.size()); end
    checks++; if (exp_q[exp_q.size()-1] !== 8'h1F) begin errors++; $display("FAIL nocks_model_last: got %h want 1f", exp_q[exp_q.size()-1]); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL nocks_byte%0d: got %h want %h", k, o, e); end
    end
    reset = 1'b1; tick(1); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; data_ready = 1'b1;
    registros = '0;
    test_reset();
    test_full();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_no_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
